perf_mon: RTL
=============

# perf_mon

Synthesizable performance and end-of-program monitor for the pipelined RV32I core. Sits beside the core top, samples the fetch instruction, the instruction-valid strobe and a parametrised vector of event strobes, and keeps saturating cycle, retired, bubble and per-event counters. When the halt instruction is fetched it waits a configurable number of cycles for the pipeline to drain, then freezes all counters and raises `o_done`.

## Interface
- `CNT_W`, 32: width of every counter.
- `NUM_EVT`, 4: number of generic event inputs, each with its own counter (≥1).
- `HALT_INSN`, 32'h0000_006f: fetch word that marks end of program (`jal x0,0`).
- `DRAIN_CYCLES`, 4: cycles counted after the halt fetch before freezing (0 allowed).

Ports:
- `i_clk` in 1: clock.
- `i_rstn` in 1: asynchronous, active-low reset.
- `i_en` in 1: count enable; also starts the run from IDLE.
- `i_clr` in 1: synchronous clear; zeroes counters, returns to IDLE.
- `i_insn_vld` in 1: core instruction-valid strobe (0 = bubble/NOP).
- `i_if_instr` in 32: instruction word currently in IF.
- `i_evt` in NUM_EVT: per-cycle event strobes (stall, flush, forward hit, ...).
- `o_cycle_cnt` out CNT_W: counted cycles.
- `o_retire_cnt` out CNT_W: counted cycles with `i_insn_vld`=1.
- `o_nop_cnt` out CNT_W: counted cycles with `i_insn_vld`=0.
- `o_evt_cnt` out NUM_EVT*CNT_W: event counters, event k in bits [k*CNT_W +: CNT_W].
- `o_state` out 2: current FSM state.
- `o_done` out 1: high in DONE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when `i_en`=1. No counting in IDLE.
- RUN: a cycle is counted when `i_en`=1. `i_en`=0 pauses counting; state holds.
- RUN → DRAIN when `i_en`=1 and `i_if_instr`==HALT_INSN; that cycle is counted. With DRAIN_CYCLES=0, go RUN → DONE directly.
- DRAIN: a down-counter loaded with DRAIN_CYCLES-1 on entry decrements every cycle regardless of `i_en`. Counters still count only when `i_en`=1. At zero → DONE.
- DONE: all counters frozen; `o_done`=1; HALT_INSN re-fetches ignored. Left only by `i_clr` or reset.
- Per counted cycle: cycle +1; retire +1 if `i_insn_vld`, else nop +1; event k +1 if `i_evt[k]`.
- All counters saturate at 2^CNT_W-1; never wrap.
- `i_clr`=1 in any state: all counters 0, drain counter 0, state IDLE next cycle. `i_clr` has priority over halt detection, `i_en` and drain expiry.

## Timing
- Reset (`i_rstn`=0, asynchronous): all counters 0, state IDLE, `o_done`=0, `o_state`=IDLE. Takes effect mid-run with no residual state.
- All outputs registered. An event in cycle N is visible on the counters from cycle N+1.
- Halt fetched in cycle N: state DRAIN from N+1, DONE from N+1+DRAIN_CYCLES. `o_done` rises the same cycle; cycles N..N+DRAIN_CYCLES are counted, given `i_en`=1 throughout.
- Invariant without saturation: `o_cycle_cnt` == `o_retire_cnt` + `o_nop_cnt`.

## Structure
- `perf_mon_pkg`: state enum `perf_state_e` (IDLE=0, RUN=1, DRAIN=2, DONE=3) and constant `HALT_JAL`=32'h0000_006f.
- Sub-module `sat_counter` (param W; `inc`, `clr`, `q`), instantiated 3+NUM_EVT times. Its reset is the same asynchronous active-low reset.
- Top holds the FSM, drain down-counter and halt compare.

## Test plan
- Reset, then `i_en`=1, vld pattern 1,1,0,1,0 for 5 cycles → cycle=5, retire=3, nop=2, state RUN.
- HALT_INSN fetched with DRAIN_CYCLES=4 and vld=1 throughout → DRAIN 4 cycles, `o_done` rises 5 cycles after the halt cycle, cycle count increments by 5 from the halt cycle on, then frozen for 20 more cycles.
- CNT_W=4, `i_evt[2]` held high 20 counted cycles → evt2=15 (saturated), cycle=15, other events 0.
- `i_en` low for 3 cycles mid-RUN → counters unchanged for those cycles; halt fetched while `i_en`=0 is ignored.
- `i_clr` in the same cycle as a halt fetch → next state IDLE, all counters 0, `o_done`=0.
- `i_rstn` asserted during DRAIN between clock edges → outputs 0 and state IDLE immediately; DRAIN_CYCLES=0 run then goes RUN→DONE in one cycle.

Source files
------------

// File: rtl/perf_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_mon_pkg
// Brief    : Shared types and constants for the performance / end-of-program
//            monitor.
// Revision : 1.0 - initial release
// ============================================================================
package perf_mon_pkg;

  // Monitor state; encoding is visible on o_state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } perf_state_e;

  // jal x0,0 : the self-loop the test programs park on when finished.
  localparam logic [31:0] HALT_JAL = 32'h0000_006f;

endpackage : perf_mon_pkg
`default_nettype wire

// File: rtl/perf_mon_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping; clr has
//            priority over inc.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] c_MAX = '1;

  logic [W-1:0] r_q;

  // Count register: clear first, then increment unless already saturated.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != c_MAX)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/perf_mon.sv
`default_nettype none
// ============================================================================
// Module   : perf_mon
// Brief    : Cycle / retire / bubble / event counters for the RV32I core with
//            halt detection, a pipeline-drain delay and a final freeze.
// Revision : 1.0 - initial release
// ============================================================================
module perf_mon
  import perf_mon_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          NUM_EVT      = 4,
  parameter logic [31:0] HALT_INSN    = HALT_JAL,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic                     i_insn_vld,
  input  logic [31:0]              i_if_instr,
  input  logic [NUM_EVT-1:0]       i_evt,
  output logic [CNT_W-1:0]         o_cycle_cnt,
  output logic [CNT_W-1:0]         o_retire_cnt,
  output logic [CNT_W-1:0]         o_nop_cnt,
  output logic [NUM_EVT*CNT_W-1:0] o_evt_cnt,
  output logic [1:0]               o_state,
  output logic                     o_done
);

  // Drain counter holds DRAIN_CYCLES-1 down to 0; keep at least one bit so
  // the DRAIN_CYCLES=0/1 builds still elaborate.
  localparam int              c_DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam bit              c_HAS_DRAIN  = (DRAIN_CYCLES > 0);
  localparam int              c_DRAIN_INIT = (DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0;
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(c_DRAIN_INIT);

  perf_state_e          r_state;
  perf_state_e          w_state_nxt;
  logic [c_DRAIN_W-1:0] r_drain_cnt;
  logic [c_DRAIN_W-1:0] w_drain_nxt;
  logic                 r_done;
  logic                 w_halt;
  logic                 w_count;

  assign w_halt  = (i_if_instr == HALT_INSN);
  // Counting happens only while the program runs or drains, gated by i_en.
  assign w_count = i_en && ((r_state == RUN) || (r_state == DRAIN));

  // State, drain counter and done flag registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_done      <= (w_state_nxt == DONE);
    end
  end

  // Next-state logic; clear overrides everything, including drain expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    if (i_clr) begin
      w_state_nxt = IDLE;
      w_drain_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_en) w_state_nxt = RUN;
        end
        RUN: begin
          if (i_en && w_halt) begin
            if (c_HAS_DRAIN) begin
              w_state_nxt = DRAIN;
              w_drain_nxt = c_DRAIN_LOAD;
            end else begin
              w_state_nxt = DONE;
            end
          end
        end
        DRAIN: begin
          // Drain time is wall-clock: it runs down even while i_en is low.
          if (r_drain_cnt == '0) w_state_nxt = DONE;
          else                   w_drain_nxt = r_drain_cnt - 1'b1;
        end
        DONE: begin
          w_state_nxt = DONE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .inc    (w_count),
    .clr    (i_clr),
    .q      (o_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .inc    (w_count && i_insn_vld),
    .clr    (i_clr),
    .q      (o_retire_cnt)
  );

  sat_counter #(.W(CNT_W)) u_nop_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .inc    (w_count && !i_insn_vld),
    .clr    (i_clr),
    .q      (o_nop_cnt)
  );

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
    sat_counter #(.W(CNT_W)) u_evt_cnt (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .inc    (w_count && i_evt[k]),
      .clr    (i_clr),
      .q      (o_evt_cnt[k*CNT_W +: CNT_W])
    );
  end

  assign o_state = r_state;
  assign o_done  = r_done;

endmodule : perf_mon
`default_nettype wire
